// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the fetch/data memory access controller:
//   - FSM state encoding (IDLE..DONE)
//   - RAM size codes carried on MS_2_0[1:0] and the fixed fetch size/sign code
//   - requester identifiers used by the arbiter and the controller
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_MOC = 3'd2,
    RELEASE  = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Size field (MS_2_0[1:0]); bit 2 of the full code selects sign extension.
  localparam logic [1:0] MS_BYTE    = 2'b00;
  localparam logic [1:0] MS_HALF    = 2'b01;
  localparam logic [1:0] MS_WORD    = 2'b10;
  localparam logic [1:0] MS_ILLEGAL = 2'b11;

  // Instruction fetch is always an unsigned word read.
  localparam logic [2:0] FETCH_MS = {1'b0, MS_WORD};

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  function automatic logic ms_is_legal(input logic [2:0] ms);
    return ms[1:0] != MS_ILLEGAL;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_rr_arbiter2
// Two-input round-robin arbiter. The grant is combinational from the current
// requests and the last_grant register; last_grant only moves when the owner
// of the granted transaction reports completion through upd_en_i/upd_id_i.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset (last_grant -> D, so F wins
//                the first tie)
//   req_f_i      fetch request
//   req_d_i      data request
//   upd_en_i     one-cycle strobe: a transaction finished
//   upd_id_i     requester whose transaction finished
//   gnt_valid_o  at least one request present
//   gnt_id_o     selected requester (meaningful when gnt_valid_o = 1)
// -----------------------------------------------------------------------------
module mem_access_ctrl_rr_arbiter2
  import mem_access_ctrl_pkg::*;
(
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    req_f_i,
  input  logic    req_d_i,
  input  logic    upd_en_i,
  input  req_id_e upd_id_i,
  output logic    gnt_valid_o,
  output req_id_e gnt_id_o
);

  req_id_e last_q, last_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt_valid_o = req_f_i | req_d_i;
    gnt_id_o    = REQ_F;
    last_d      = last_q;
    if (req_f_i && req_d_i) begin
      // Tie: hand the slot to whoever did not go last.
      gnt_id_o = (last_q == REQ_D) ? REQ_F : REQ_D;
    end else if (req_d_i) begin
      gnt_id_o = REQ_D;
    end
    if (upd_en_i) begin
      last_d = upd_id_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= REQ_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Shares one byte-addressed RAM (MOV/MOC handshake) between instruction fetch
// (F) and load/store data (D). A round-robin arbiter picks a requester in
// IDLE; the controller then latches that request and runs
// ISSUE -> WAIT_MOC -> RELEASE -> DONE, returning a one-cycle Ack.
// Illegal data sizes skip the RAM and complete immediately with D_Err.
// WAIT_MOC is bounded by TIMEOUT_CYCLES; an expired wait completes with D_Err.
//
// Ports (CPU side):
//   Clk, Reset          clock, synchronous active-high reset
//   F_Req/F_Addr        fetch request (level) and word address
//   F_Ack/F_Data        fetch done pulse / fetched word (held)
//   D_Req/D_RW/D_MS     data request, 1=read, size/sign code
//   D_Addr/D_WData      data address / write data
//   D_Ack/D_RData/D_Err data done pulse / read data (held) / error with Ack
// Ports (RAM side, all registered):
//   MOV, ReadWrite, MS_2_0, Address, DataIn, MOCoff   outputs
//   MOC, DataOut                                       inputs
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        F_Req,
  input  logic [31:0] F_Addr,
  output logic        F_Ack,
  output logic [31:0] F_Data,
  input  logic        D_Req,
  input  logic        D_RW,
  input  logic [2:0]  D_MS,
  input  logic [31:0] D_Addr,
  input  logic [31:0] D_WData,
  output logic        D_Ack,
  output logic [31:0] D_RData,
  output logic        D_Err,
  output logic        MOV,
  output logic        ReadWrite,
  output logic [2:0]  MS_2_0,
  output logic [31:0] Address,
  output logic [31:0] DataIn,
  output logic        MOCoff,
  input  logic        MOC,
  input  logic [31:0] DataOut
);

  // Value of the counter during the last permitted WAIT_MOC cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  req_id_e           grant_q, grant_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mov_q, mov_d;
  logic              mocoff_q, mocoff_d;
  logic              rw_q, rw_d;
  logic [2:0]        ms_q, ms_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       f_data_q, f_data_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;

  logic              arb_valid;
  req_id_e           arb_id;
  logic              arb_upd;

  mem_access_ctrl_rr_arbiter2 u_arb (
    .clk_i       (Clk),
    .reset_i     (Reset),
    .req_f_i     (F_Req),
    .req_d_i     (D_Req),
    .upd_en_i    (arb_upd),
    .upd_id_i    (grant_q),
    .gnt_valid_o (arb_valid),
    .gnt_id_o    (arb_id)
  );

  // Next-state and next-output logic. Outputs are computed one state ahead so
  // that every RAM/CPU output comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    mov_d     = mov_q;
    mocoff_d  = mocoff_q;
    rw_d      = rw_q;
    ms_d      = ms_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f_data_d  = f_data_q;
    d_rdata_d = d_rdata_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    arb_upd   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_id;
          err_d   = 1'b0;
          if (arb_id == REQ_F) begin
            rw_d     = 1'b1;
            ms_d     = FETCH_MS;
            addr_d   = F_Addr;
            wdata_d  = '0;
            mov_d    = 1'b1;
            mocoff_d = 1'b1;
            state_d  = ISSUE;
          end else if (!ms_is_legal(D_MS)) begin
            // Illegal size: answer at once, RAM-side registers untouched.
            err_d   = 1'b1;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
            state_d = DONE;
          end else begin
            rw_d     = D_RW;
            ms_d     = D_MS;
            addr_d   = D_Addr;
            wdata_d  = D_WData;
            mov_d    = 1'b1;
            mocoff_d = 1'b1;
            state_d  = ISSUE;
          end
        end
      end

      ISSUE: begin
        // MOCoff was high for this cycle only, clearing any stale MOC.
        mocoff_d = 1'b0;
        cnt_d    = '0;
        state_d  = WAIT_MOC;
      end

      WAIT_MOC: begin
        if (MOC) begin
          // MOC wins even on the final counted cycle.
          if (rw_q) begin
            if (grant_q == REQ_F) f_data_d  = DataOut;
            else                  d_rdata_d = DataOut;
          end
          mov_d    = 1'b0;
          mocoff_d = 1'b1;
          state_d  = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          err_d    = 1'b1;
          mov_d    = 1'b0;
          mocoff_d = 1'b1;
          state_d  = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        mocoff_d = 1'b0;
        f_ack_d  = (grant_q == REQ_F);
        d_ack_d  = (grant_q == REQ_D);
        d_err_d  = (grant_q == REQ_D) && err_q;
        state_d  = DONE;
      end

      DONE: begin
        arb_upd = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      grant_q   <= REQ_F;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      mov_q     <= 1'b0;
      mocoff_q  <= 1'b0;
      rw_q      <= 1'b0;
      ms_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_data_q  <= '0;
      d_rdata_q <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      mov_q     <= mov_d;
      mocoff_q  <= mocoff_d;
      rw_q      <= rw_d;
      ms_q      <= ms_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_data_q  <= f_data_d;
      d_rdata_q <= d_rdata_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
    end
  end

  assign MOV       = mov_q;
  assign MOCoff    = mocoff_q;
  assign ReadWrite = rw_q;
  assign MS_2_0    = ms_q;
  assign Address   = addr_q;
  assign DataIn    = wdata_q;
  assign F_Data    = f_data_q;
  assign D_RData   = d_rdata_q;
  assign F_Ack     = f_ack_q;
  assign D_Ack     = d_ack_q;
  assign D_Err     = d_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. A behavioural big-endian RAM answers the
// handshake: MOC rises once MOV has been high (with MOCoff low) for moc_delay
// cycles; half/word accesses align the address down; reads size/sign-extend
// according to MS_2_0.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        F_Req;
  logic [31:0] F_Addr;
  logic        F_Ack;
  logic [31:0] F_Data;
  logic        D_Req;
  logic        D_RW;
  logic [2:0]  D_MS;
  logic [31:0] D_Addr;
  logic [31:0] D_WData;
  logic        D_Ack;
  logic [31:0] D_RData;
  logic        D_Err;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        MOCoff;
  logic        MOC;
  logic [31:0] DataOut;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .F_Req     (F_Req),
    .F_Addr    (F_Addr),
    .F_Ack     (F_Ack),
    .F_Data    (F_Data),
    .D_Req     (D_Req),
    .D_RW      (D_RW),
    .D_MS      (D_MS),
    .D_Addr    (D_Addr),
    .D_WData   (D_WData),
    .D_Ack     (D_Ack),
    .D_RData   (D_RData),
    .D_Err     (D_Err),
    .MOV       (MOV),
    .ReadWrite (ReadWrite),
    .MS_2_0    (MS_2_0),
    .Address   (Address),
    .DataIn    (DataIn),
    .MOCoff    (MOCoff),
    .MOC       (MOC),
    .DataOut   (DataOut)
  );

  // ---------------- RAM model ----------------
  logic [7:0] mem [0:255];
  int         moc_delay = 0;
  int         wait_cnt  = 0;
  logic       bd_we     = 1'b0;
  logic [7:0] bd_addr   = 8'h00;
  logic [7:0] bd_data   = 8'h00;
  logic [7:0] ra, rh, rw;
  logic       ram_active;

  assign ram_active = MOV && !MOCoff;
  assign MOC        = ram_active && (wait_cnt >= moc_delay);

  always_comb begin
    ra = Address[7:0];
    rh = {ra[7:1], 1'b0};
    rw = {ra[7:2], 2'b00};
    case (MS_2_0[1:0])
      2'b00:   DataOut = MS_2_0[2] ? {{24{mem[ra][7]}}, mem[ra]} : {24'h0, mem[ra]};
      2'b01:   DataOut = MS_2_0[2] ? {{16{mem[rh][7]}}, mem[rh], mem[rh + 8'd1]}
                                   : {16'h0, mem[rh], mem[rh + 8'd1]};
      default: DataOut = {mem[rw], mem[rw + 8'd1], mem[rw + 8'd2], mem[rw + 8'd3]};
    endcase
  end

  always @(posedge Clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    wait_cnt <= ram_active ? wait_cnt + 1 : 0;
    if (MOC && !ReadWrite) begin
      case (MS_2_0[1:0])
        2'b00: mem[ra] <= DataIn[7:0];
        2'b01: begin
          mem[rh]        <= DataIn[15:8];
          mem[rh + 8'd1] <= DataIn[7:0];
        end
        default: begin
          mem[rw]        <= DataIn[31:24];
          mem[rw + 8'd1] <= DataIn[23:16];
          mem[rw + 8'd2] <= DataIn[15:8];
          mem[rw + 8'd3] <= DataIn[7:0];
        end
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge Clk);
    bd_we   = 1'b0;
  endtask

  // Results of the last run() call.
  int          r_lat;
  int          r_mov;
  int          r_mask;
  logic        r_other;
  logic [31:0] r_fdata;
  logic [31:0] r_drdata;
  logic        r_derr;

  // Raise one request, wait (bounded) for its Ack, drop the request and let
  // the FSM get back to IDLE. Latency counts edges from the sampling edge.
  task automatic run(input logic is_f);
    r_lat = -1; r_mov = 0; r_mask = 0; r_other = 1'b0;
    @(negedge Clk);
    if (is_f) F_Req = 1'b1; else D_Req = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge Clk);
      #1;
      if (MOV) r_mov++;
      if (MOCoff && c < 31) r_mask |= (1 << c);
      if (is_f ? D_Ack : F_Ack) r_other = 1'b1;
      if (is_f ? F_Ack : D_Ack) begin
        r_lat    = c;
        r_fdata  = F_Data;
        r_drdata = D_RData;
        r_derr   = D_Err;
        break;
      end
    end
    F_Req = 1'b0;
    D_Req = 1'b0;
    @(posedge Clk);
  endtask

  task automatic set_d(input logic rw_i, input logic [2:0] ms, input logic [31:0] a,
                       input logic [31:0] wd);
    D_RW = rw_i; D_MS = ms; D_Addr = a; D_WData = wd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] order;
    int         nacks;
    logic       both;

    Reset = 1'b1;
    F_Req = 1'b0; F_Addr = '0;
    D_Req = 1'b0; D_RW = 1'b0; D_MS = '0; D_Addr = '0; D_WData = '0;

    // Preload during reset: word 0xDEADBEEF at 0x10, byte 0x80 at 0x30.
    poke(8'h10, 8'hDE); poke(8'h11, 8'hAD); poke(8'h12, 8'hBE); poke(8'h13, 8'hEF);
    poke(8'h30, 8'h80);
    @(posedge Clk); #1;
    check("reset_ctrl", {F_Ack, D_Ack, D_Err, MOV, ReadWrite, MS_2_0, MOCoff}, '0);
    check("reset_addr", Address, 32'h0);
    check("reset_din", DataIn, 32'h0);
    check("reset_fdata", F_Data, 32'h0);
    check("reset_drdata", D_RData, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Both requesters held high: F wins the first tie, then strict alternation.
    F_Addr = 32'h10;
    set_d(1'b1, 3'b000, 32'h30, 32'h0);
    F_Req = 1'b1; D_Req = 1'b1;
    order = '0; nacks = 0; both = 1'b0;
    for (int c = 0; c < 60 && nacks < 4; c++) begin
      @(posedge Clk); #1;
      if (F_Ack && D_Ack) both = 1'b1;
      if (F_Ack) begin
        order = {order[2:0], 1'b0}; nacks++;
        check("rr_fdata", F_Data, 32'hDEADBEEF);
      end else if (D_Ack) begin
        order = {order[2:0], 1'b1}; nacks++;
        check("rr_drdata", D_RData, 32'h80);
      end
    end
    F_Req = 1'b0; D_Req = 1'b0;
    @(posedge Clk);
    check("rr_order", order, 4'b0101);
    check("rr_nacks", nacks, 4);
    check("rr_both_ack", both, 1'b0);

    // Fetch of a preloaded word: minimum latency, MOV two cycles,
    // MOCoff pulses in ISSUE (cycle 1) and RELEASE (cycle 3).
    F_Addr = 32'h10;
    run(1'b1);
    check("f_lat", r_lat, 4);
    check("f_mov_cycles", r_mov, 2);
    check("f_mocoff_mask", r_mask, 32'hA);
    check("f_data", r_fdata, 32'hDEADBEEF);
    check("f_other_ack", r_other, 1'b0);

    // Half write at an odd address (aligned by the RAM), D_RData untouched.
    set_d(1'b0, 3'b001, 32'h21, 32'h1234);
    run(1'b0);
    check("dw_lat", r_lat, 4);
    check("dw_err", r_derr, 1'b0);
    check("dw_rdata_held", r_drdata, 32'h80);
    check("dw_other_ack", r_other, 1'b0);

    // Signed half read of the written value (positive -> zero upper half).
    set_d(1'b1, 3'b101, 32'h20, 32'h0);
    run(1'b0);
    check("dr_half_lat", r_lat, 4);
    check("dr_half_data", r_drdata, 32'h00001234);
    check("dr_half_err", r_derr, 1'b0);

    // Byte 0x80 read signed then unsigned.
    set_d(1'b1, 3'b100, 32'h30, 32'h0);
    run(1'b0);
    check("dr_sbyte", r_drdata, 32'hFFFFFF80);
    set_d(1'b1, 3'b000, 32'h30, 32'h0);
    run(1'b0);
    check("dr_ubyte", r_drdata, 32'h00000080);

    // Illegal size: Ack one cycle after sampling, error, RAM never strobed.
    set_d(1'b1, 3'b011, 32'h30, 32'h0);
    run(1'b0);
    check("ill_lat", r_lat, 1);
    check("ill_err", r_derr, 1'b1);
    check("ill_mov", r_mov, 0);
    check("ill_mocoff", r_mask, 0);
    check("ill_rdata_held", r_drdata, 32'h80);

    // No MOC ever: 15 WAIT_MOC cycles, then error; data register unchanged.
    moc_delay = 1000;
    set_d(1'b1, 3'b001, 32'h20, 32'h0);
    run(1'b0);
    check("to_lat", r_lat, 18);
    check("to_err", r_derr, 1'b1);
    check("to_mov_cycles", r_mov, 16);
    check("to_rdata_held", r_drdata, 32'h80);

    // MOC arrives exactly on the last permitted WAIT_MOC cycle: success.
    moc_delay = 14;
    set_d(1'b1, 3'b001, 32'h20, 32'h0);
    run(1'b0);
    check("edge_lat", r_lat, 18);
    check("edge_err", r_derr, 1'b0);
    check("edge_data", r_drdata, 32'h00001234);

    // Reset in the middle of WAIT_MOC: everything clears on the next edge.
    moc_delay = 1000;
    set_d(1'b1, 3'b010, 32'h10, 32'h0);
    @(negedge Clk);
    D_Req = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check("mid_mov_before", MOV, 1'b1);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("mid_ctrl", {F_Ack, D_Ack, D_Err, MOV, ReadWrite, MS_2_0, MOCoff}, '0);
    check("mid_addr", Address, 32'h0);
    check("mid_drdata", D_RData, 32'h0);
    @(negedge Clk);
    Reset = 1'b0; D_Req = 1'b0; moc_delay = 0;
    @(negedge Clk);

    F_Addr = 32'h10;
    run(1'b1);
    check("post_lat", r_lat, 4);
    check("post_data", r_fdata, 32'hDEADBEEF);
    check("post_mocoff_mask", r_mask, 32'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
